// File: rtl/fc_ctrl_pkg.sv
// Shared encodings for the fully-connected job controller and the datapath that consumes its selects.
package fc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_B   = 3'd1,
    LOAD_ROW = 3'd2,
    COMPUTE  = 3'd3,
    DRAIN    = 3'd4
  } fc_state_e;

  localparam int ROW_W        = 2;
  localparam int NUM_ROWS     = 4;
  localparam int PIPE_LAT_DEF = 4;

endpackage

// File: rtl/fc_sequencer.sv
// Start-triggered job controller: paces bias/row loads on a valid/ready stream, holds the MAC
// enable for PIPE_LAT cycles, then drains four result rows under output back-pressure.
module fc_sequencer
  import fc_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int ROWS     = NUM_ROWS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             enb_dffb,
  output logic             enb_dff8,
  output logic [ROW_W-1:0] sel_dff8,
  output logic             enb_m4,
  output logic             enb_out,
  output logic [ROW_W-1:0] sel_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int               LAT_W    = $clog2(PIPE_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  fc_state_e        state_q, state_d;
  logic [ROW_W-1:0] row_cnt_q, row_cnt_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      lat_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      lat_cnt_q <= lat_cnt_d;
      done_q    <= done_d;
    end
  end

  // Abort overrides every transition and suppresses the done pulse of a finishing job.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    lat_cnt_d = lat_cnt_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      row_cnt_d = '0;
      lat_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          row_cnt_d = '0;
          lat_cnt_d = '0;
          if (start) state_d = LOAD_B;
        end
        LOAD_B: begin
          if (in_valid) state_d = LOAD_ROW;
        end
        LOAD_ROW: begin
          if (in_valid) begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
            if (row_cnt_q == ROW_LAST) begin
              state_d   = COMPUTE;
              lat_cnt_d = '0;
            end
          end
        end
        COMPUTE: begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
          if (lat_cnt_q == LAT_LAST) begin
            state_d   = DRAIN;
            lat_cnt_d = '0;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            row_cnt_d = row_cnt_q + ROW_W'(1);
            if (row_cnt_q == ROW_LAST) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    done      = done_q;
    in_ready  = 1'b0;
    enb_dffb  = 1'b0;
    enb_dff8  = 1'b0;
    sel_dff8  = '0;
    enb_m4    = 1'b0;
    enb_out   = 1'b0;
    sel_out   = '0;
    out_valid = 1'b0;
    unique case (state_q)
      LOAD_B: begin
        in_ready = 1'b1;
        enb_dffb = in_valid;
      end
      LOAD_ROW: begin
        in_ready = 1'b1;
        enb_dff8 = in_valid;
        sel_dff8 = row_cnt_q;
      end
      COMPUTE: enb_m4 = 1'b1;
      DRAIN: begin
        enb_out   = 1'b1;
        out_valid = 1'b1;
        sel_out   = row_cnt_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fc_sequencer.sv
// Directed bench for fc_sequencer: a vector table for the unstalled job plus hand-written stall,
// abort and reset sequences.
module tb_fc_sequencer;

  localparam int PIPE_LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic       busy, done, in_ready, enb_dffb, enb_dff8, enb_m4, enb_out, out_valid;
  logic [1:0] sel_dff8, sel_out;

  int checks = 0;
  int errors = 0;
  int m4_run = 0;
  int m4_last = 0;
  int dff8_cnt = 0;

  always #5 clk = ~clk;

  fc_sequencer #(.PIPE_LAT(PIPE_LAT), .ROWS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .enb_dffb(enb_dffb), .enb_dff8(enb_dff8), .sel_dff8(sel_dff8),
    .enb_m4(enb_m4), .enb_out(enb_out), .sel_out(sel_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    logic       st, ab, iv, ordy;
    logic [11:0] exp_obs;
  } vec_t;

  function automatic logic [11:0] pack(input logic b, d, ir, eb, e8, input logic [1:0] s8,
                                       input logic m4, eo, input logic [1:0] so, input logic ov);
    return {b, d, ir, eb, e8, s8, m4, eo, so, ov};
  endfunction

  function automatic logic [11:0] obs();
    return pack(busy, done, in_ready, enb_dffb, enb_dff8, sel_dff8, enb_m4, enb_out, sel_out, out_valid);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    m4_run = 0;
    m4_last = 0;
    dff8_cnt = 0;
  endtask

  // One clock cycle: inputs change on the falling edge, outputs are sampled 1 ns later.
  task automatic step(input logic s, a, iv, ordy);
    @(negedge clk);
    start = s; abort = a; in_valid = iv; out_ready = ordy;
    #1;
    if (enb_m4) m4_run++;
    else if (m4_run != 0) begin
      m4_last = m4_run;
      m4_run = 0;
    end
    if (enb_dff8) dff8_cnt++;
    if (done) begin
      chk("mac_enable_run_length", m4_last, PIPE_LAT);
      chk("row_load_count", dff8_cnt, 4);
      mon_clear();
    end
  endtask

  // Runs one job from a start at cycle 0; windows are absolute cycle ranges (from > to disables).
  task automatic run_job(input string name, input int ivf, ivt, input int exp_s8,
                         input int orf, ort, input int exp_so, input int stf, stt,
                         input int exp_done);
    int done_cyc = -1;
    int acc_row = 0;
    step(1, 0, 1, 1);
    for (int cyc = 1; cyc < 60; cyc++) begin
      logic iv, ordy, st;
      iv   = !(cyc >= ivf && cyc <= ivt);
      ordy = !(cyc >= orf && cyc <= ort);
      st   = (cyc >= stf && cyc <= stt);
      step(st, 0, iv, ordy);
      if (!iv) begin
        chk({name, "_gap_sel_dff8"}, int'(sel_dff8), exp_s8);
        chk({name, "_gap_enb_dff8"}, int'(enb_dff8), 0);
        chk({name, "_gap_in_ready"}, int'(in_ready), 1);
      end
      if (!ordy) begin
        chk({name, "_hold_sel_out"}, int'(sel_out), exp_so);
        chk({name, "_hold_out_valid"}, int'(out_valid), 1);
      end
      if (out_valid && ordy) begin
        chk({name, "_accept_row"}, int'(sel_out), acc_row);
        acc_row++;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
    end
    chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_rows_accepted"}, acc_row, 4);
  endtask

  vec_t vecs[18];

  initial begin
    vecs[0] = '{1, 0, 1, 1, pack(0,0,0,0,0,2'd0,0,0,2'd0,0)};
    vecs[1] = '{0, 0, 1, 1, pack(1,0,1,1,0,2'd0,0,0,2'd0,0)};
    for (int r = 0; r < 4; r++) begin
      vecs[2+r]  = '{0, 0, 1, 1, pack(1,0,1,0,1,2'(r),0,0,2'd0,0)};
      vecs[6+r]  = '{0, 0, 1, 1, pack(1,0,0,0,0,2'd0,1,0,2'd0,0)};
      vecs[10+r] = '{0, 0, 1, 1, pack(1,0,0,0,0,2'd0,0,1,2'(r),1)};
    end
    vecs[14] = '{1, 0, 1, 1, pack(0,1,0,0,0,2'd0,0,0,2'd0,0)};
    vecs[15] = '{0, 0, 0, 1, pack(1,0,1,0,0,2'd0,0,0,2'd0,0)};
    vecs[16] = '{0, 1, 0, 1, pack(1,0,1,0,0,2'd0,0,0,2'd0,0)};
    vecs[17] = '{0, 0, 1, 1, pack(0,0,0,0,0,2'd0,0,0,2'd0,0)};

    #12;
    chk("reset_outputs", int'(obs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0);
    chk("idle_after_reset", int'(obs()), 0);

    // Unstalled job, back-to-back start in the done cycle, load stall, then abort in LOAD_B.
    for (int i = 0; i < 18; i++) begin
      step(vecs[i].st, vecs[i].ab, vecs[i].iv, vecs[i].ordy);
      chk($sformatf("table_cycle_%0d", i), int'(obs()), int'(vecs[i].exp_obs));
    end
    mon_clear();

    run_job("in_gap", 3, 5, 1, 99, 0, 0, 99, 0, 17);
    step(0, 0, 0, 0);
    run_job("out_stall", 99, 0, 0, 12, 13, 2, 99, 0, 16);
    step(0, 0, 0, 0);

    run_job("start_in_compute", 99, 0, 0, 99, 0, 0, 6, 9, 14);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("no_second_job_busy", int'(busy), 0);

    // Abort while waiting for row 2.
    step(1, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(0, 1, 0, 1);
    chk("abort_at_row2_sel", int'(sel_dff8), 2);
    step(0, 0, 1, 1);
    chk("abort_returns_idle", int'(obs()), 0);
    step(0, 0, 1, 1);
    chk("abort_no_done", int'(done), 0);
    mon_clear();

    step(1, 1, 1, 1);
    step(0, 0, 1, 1);
    chk("abort_beats_start", int'(busy), 0);

    // Reset asserted mid-COMPUTE at cycle 7.
    step(1, 0, 1, 1);
    for (int c = 1; c < 7; c++) step(0, 0, 1, 1);
    chk("pre_reset_in_compute", int'(enb_m4), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_compute", int'(obs()), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mon_clear();
    step(0, 0, 0, 0);
    chk("no_done_after_reset", int'(done), 0);
    run_job("after_reset", 99, 0, 0, 99, 0, 0, 99, 0, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fc_sequencer.md
# fc_sequencer

Handshaked job controller for the 4x4 fully-connected matrix datapath. It replaces the free-running load/compute/output counter with a start-triggered state machine that:
- paces bias and row loading on a valid/ready input stream,
- holds the multiply-accumulate pipeline enable for exactly its latency,
- drains the four result rows under output back-pressure.

It sits between the host-side stream logic and the datapath enables/selects.

## Interface
Parameters:
- PIPE_LAT, 4, number of cycles the MAC pipeline enable is held (product, two sum stages, clamp)
- ROWS, 4, rows per job; fixed at 4, row index is 2 bits

Ports (reset is asynchronous and active-low, one clock):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  synchronous abort; returns to IDLE from any state
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse after the last result row is accepted
- in_valid  in  1  load beat valid (bias or one W/X row on the datapath buses)
- in_ready  out  1  high in LOAD_B and LOAD_ROW
- enb_dffb  out  1  bias register load enable
- enb_dff8  out  1  W/X row register load enable
- sel_dff8  out  2  row select for W/X load
- enb_m4  out  1  MAC pipeline enable
- enb_out  out  1  output mux enable
- sel_out  out  2  output row select
- out_valid  out  1  result row presented
- out_ready  in  1  result row accepted when out_valid & out_ready

## Operation
States: IDLE, LOAD_B, LOAD_ROW, COMPUTE, DRAIN. Counters: row_cnt (2 b), lat_cnt (clog2(PIPE_LAT+1) b).
- IDLE: start=1 -> LOAD_B. row_cnt=0.
- LOAD_B: in_ready=1; enb_dffb=in_valid. On beat -> LOAD_ROW.
- LOAD_ROW: in_ready=1; enb_dff8=in_valid; sel_dff8=row_cnt. Each beat increments row_cnt. A beat at row_cnt=3 -> COMPUTE, with row_cnt wrapping to 0 and lat_cnt=0.
- COMPUTE: enb_m4=1; lat_cnt increments. lat_cnt=PIPE_LAT-1 -> DRAIN.
- DRAIN: enb_out=1, out_valid=1, sel_out=row_cnt. An accept increments row_cnt. An accept at row_cnt=3 -> IDLE with done=1 in the following cycle.
- All enables/selects are combinational from state, counters and handshake inputs. Outside their states, enables are 0 and selects are 0.
- enb_dff8/enb_dffb are never high without in_valid & in_ready.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, counters=0. busy, done, in_ready, out_valid and all enables/selects = 0.
- No stalls: start sampled at cycle 0. Bias loads at cycle 1, rows at cycles 2–5, COMPUTE at cycles 6–9, rows 0–3 are output at cycles 10–13, and done is high at cycle 14. Total latency 14 cycles (PIPE_LAT=4).
- Load stall: in_valid=0 in a load state keeps the state, row_cnt and enables at 0.
- Output stall: out_ready=0 holds sel_out, enb_out and out_valid stable; the row is not skipped.
- start while busy: ignored, never queued. start in the done cycle (state IDLE) is accepted.
- abort: highest priority. The next state is IDLE with counters cleared and no done pulse. Datapath registers are untouched.
- abort and start in the same IDLE cycle: abort wins, stay IDLE.
- Reset mid-job: immediate return to IDLE values. No done pulse.

## Structure
- Package fc_ctrl_pkg holds the state encoding (3-bit enum IDLE..DRAIN), ROW_W=2, NUM_ROWS=4 and the default PIPE_LAT. The datapath top imports it for sel widths.
- Single module, no sub-module. Counters and output decode are inline.

## Test plan
- Reset mid-COMPUTE (rst_n low at cycle 7): all outputs 0 immediately, busy=0, and the next start runs a full 14-cycle job.
- Back-to-back jobs, no stalls, W=all 1, X=all 2, bias=0x01020304: done at cycle 14. Each output row shows enb_out=1 with sel_out 0,1,2,3 on cycles 10–13. A start in the done cycle gives busy=1 at cycle 15.
- in_valid deasserted for 3 cycles after row 1: sel_dff8 stays 1 and enb_dff8=0 during the gap. done is delayed by exactly 3 cycles (cycle 17).
- out_ready low for 2 cycles on row 2: sel_out=2 and out_valid=1 are held. Each row is accepted exactly once, and done is at cycle 16.
- abort in LOAD_ROW at row_cnt=2: IDLE next cycle, busy=0, no done, in_ready=0. start during COMPUTE is ignored, with no second job.
- Assertion: enb_m4 is high for exactly PIPE_LAT consecutive cycles per job, and enb_dff8 is high exactly 4 times per job.
